arm_lsu: RTL
============

# arm_lsu

Parametrised load/store unit between the ARM core's memory stage and a variable-latency data memory. It accepts one byte, halfword, word or doubleword access at a time and generates byte enables and lane-replicated write data. It extracts and sign- or zero-extends load data, and stalls the core until the memory acknowledges. Misaligned accesses and memory timeouts are reported as error responses without corrupting memory.

## Interface
- DATA_W, 32, memory/data bus width; 32 or 64
- ADDR_W, 32, byte address width
- TIMEOUT, 16, max cycles waiting for mem_ack before error; 0 disables timeout
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  core access request
- req_ready  out  1  LSU idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_err  out  1  qualifies resp_valid: misaligned/illegal size or timeout
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- stall  out  1  LSU busy (= !req_ready)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits zeroed
- mem_be  out  DATA_W/8  byte enables
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- mem_rdata  in  DATA_W  valid in the cycle mem_ack=1 for loads

## Operation
- The FSM has four states. IDLE, ACCESS, DONE and ERR are one-hot or encoded, implementer's choice.
- IDLE: req_ready=1. If req_valid=1, latch we/size/signed/addr/wdata.
  - If the access is illegal, go to ERR. Otherwise go to ACCESS and clear the wait counter.
- Illegal access, any of:
  - size=3 with DATA_W=32
  - addr not a multiple of 2^size bytes
- ACCESS: mem_req=1, all mem_* outputs stable from latched values.
  - On mem_ack=1: capture load data and go to DONE.
  - Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1, go to ERR.
  - Else increment the counter, saturating.
- DONE: resp_valid=1, resp_err=0, then go to IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, then go to IDLE. No memory request is issued for illegal accesses.
- Byte offset: off = addr[log2(DATA_W/8)-1:0].
- Byte enables, with mem_be=0 outside ACCESS:
  - byte: 1<<off
  - half: 0x3<<off
  - word: 0xF<<off
  - dword: all ones
- Write data is replicated per size:
  - byte: wdata[7:0] in every lane
  - half: wdata[15:0] in every halfword
  - word: wdata[31:0] in every word
- Load data: (mem_rdata >> 8*off), masked to the access size, then extended to DATA_W (sign if req_signed, else zero). Dword loads ignore req_signed.
- Stores: resp_rdata=0.

## Timing
- Reset values, async on reset=0:
  - state IDLE, counter 0
  - req_ready=1, stall=0
  - resp_valid=0, resp_err=0, resp_rdata=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
- Accept in cycle 0. mem_req is high from cycle 1.
- If mem_ack arrives in cycle k≥1, resp_valid is high in cycle k+1 and req_ready returns in cycle k+2.
- Minimum total latency is 2 cycles from accept to resp_valid (ack in the same cycle mem_req rises).
- An illegal access gives resp_valid in cycle 1 with mem_req never asserted.
- Timeout: if no ack during TIMEOUT consecutive ACCESS cycles, ERR follows and mem_req drops. A later mem_ack is ignored.
- Requests in non-IDLE states are not accepted. The core holds req_valid/req_* while stall=1.
- resp_rdata is registered and holds its value until the next resp_valid.
- Reset mid-ACCESS drops mem_req immediately (asynchronously). No response is generated for the aborted access.

## Test plan
- Store byte 0xA5 to addr 0x1003, DATA_W=32, ack after 2 cycles:
  - mem_addr=0x1000, mem_be=0b1000, mem_wdata=0xA5A5A5A5, mem_we=1
  - resp_valid in cycle 3, resp_err=0
- Signed halfword load from 0x2002, mem_rdata=0x80017FFF, immediate ack:
  - resp_rdata=0xFFFF8001
  - Repeat unsigned: resp_rdata=0x00008001
- Word load from 0x3002 (misaligned):
  - resp_valid+resp_err in cycle 1, mem_req never high, resp_rdata=0
- Load with TIMEOUT=4 and mem_ack never asserted:
  - mem_req high exactly 4 cycles, then resp_err=1
  - A late ack is ignored and the LSU returns to IDLE
- DATA_W=64:
  - dword store 0x1122334455667788 to 0x18 gives mem_be=0xFF
  - word load from 0x1C with mem_rdata=0xDEADBEEF_00000000 gives resp_rdata=0x00000000DEADBEEF
  - size=3 with DATA_W=32 gives an error
- Reset asserted in the 3rd ACCESS cycle:
  - all outputs at reset values the same cycle
  - no resp_valid
  - the next request completes normally

Source files
------------

// File: rtl/arm_lsu.sv
// Load/store unit between the core memory stage and a variable-latency data memory:
// size/alignment checks, byte enables, lane replication, load extraction and timeout.
module arm_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t              state, state_nx;
    logic                we_q, signed_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [31:0]         cnt_q;
    logic                illegal, timed_out, sign_bit;
    logic [OFF_W-1:0]    off;
    logic [DATA_W-1:0]   shifted, size_mask, load_ext;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and each request yields exactly one resp_valid pulse.
    assign req_ready  = (state == IDLE);
    assign stall      = !req_ready;
    assign resp_valid = (state == DONE) || (state == ERR);
    assign resp_err   = (state == ERR);
    assign resp_rdata = rdata_q;
    assign mem_req    = (state == ACCESS);
    assign mem_we     = (state == ACCESS) && we_q;
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dbg_state  = state;
    assign off        = addr_q[OFF_W-1:0];
    assign timed_out  = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        illegal = 1'b0;
        case (req_size)
            2'd0:    illegal = 1'b0;
            2'd1:    illegal = req_addr[0];
            2'd2:    illegal = |req_addr[1:0];
            default: illegal = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = illegal ? ERR : ACCESS;
            ACCESS: begin
                if (mem_ack)        state_nx = DONE;
                else if (timed_out) state_nx = ERR;
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane 0 of the shifted bus holds the addressed bytes; the mask keeps only the access size.
    always_comb begin
        shifted   = mem_rdata >> {off, 3'b000};
        size_mask = '1;
        sign_bit  = 1'b0;
        case (size_q)
            2'd0: begin size_mask = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
            2'd1: begin size_mask = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
            2'd2: begin size_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: begin size_mask = '1;                  sign_bit = 1'b0;        end
        endcase
        load_ext = (shifted & size_mask) | ((signed_q && sign_bit) ? ~size_mask : '0);
    end

    always_comb begin
        mem_be = '0;
        if (state == ACCESS) begin
            case (size_q)
                2'd0:    mem_be = BE_W'(1)    << off;
                2'd1:    mem_be = BE_W'(3)    << off;
                2'd2:    mem_be = BE_W'(4'hF) << off;
                default: mem_be = '1;
            endcase
        end
    end

    always_comb begin
        mem_wdata = wdata_q;
        case (size_q)
            2'd0:    mem_wdata = {(DATA_W/8){wdata_q[7:0]}};
            2'd1:    mem_wdata = {(DATA_W/16){wdata_q[15:0]}};
            2'd2:    mem_wdata = {(DATA_W/32){wdata_q[31:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                cnt_q    <= '0;
            end else if (state == ACCESS && !mem_ack && cnt_q != '1) begin
                cnt_q <= cnt_q + 32'd1;
            end
            // Result register changes only when a response is about to be presented.
            if (state == ACCESS && mem_ack) rdata_q <= we_q ? '0 : load_ext;
            else if (state_nx == ERR)       rdata_q <= '0;
        end
    end
endmodule
